// File: rtl/axi_gp_pkg.sv
// axi_gp_pkg: response codes and FSM state types shared by the AXI3-to-AXI-lite bridge.
package axi_gp_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [2:0] {W_IDLE, W_COLLECT, W_ISSUE, W_DRAIN, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_RESP, R_ERR} r_state_e;
endpackage

// File: rtl/axi_gp_rd_chan.sv
// axi_gp_rd_chan: read FSM; single beats go downstream, bursts are answered locally with SLVERR beats.
module axi_gp_rd_chan import axi_gp_pkg::*; #(
  parameter int ID_W = 12,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WINDOW_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ID_W-1:0]   s_arid,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic [3:0]        s_arlen,
  input  logic [2:0]        s_arprot,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [ID_W-1:0]   s_rid,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arprot,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);
  r_state_e r_st_q, r_st_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ID_W-1:0] s_rid_q, s_rid_d;
  logic [DATA_W-1:0] s_rdata_q, s_rdata_d;
  logic [1:0] s_rresp_q, s_rresp_d;
  logic [ADDR_W-1:0] m_araddr_q, m_araddr_d;
  logic [2:0] m_arprot_q, m_arprot_d;
  logic s_arready_q, s_arready_d, s_rlast_q, s_rlast_d, s_rvalid_q, s_rvalid_d;
  logic m_arvalid_q, m_arvalid_d, m_rready_q, m_rready_d;
  always_comb begin
    r_st_d = r_st_q;
    cnt_d = cnt_q;
    s_rid_d = s_rid_q;
    s_rdata_d = s_rdata_q;
    s_rresp_d = s_rresp_q;
    s_rlast_d = s_rlast_q;
    s_rvalid_d = s_rvalid_q;
    m_araddr_d = m_araddr_q;
    m_arprot_d = m_arprot_q;
    m_arvalid_d = m_arvalid_q;
    m_rready_d = m_rready_q;
    case (r_st_q)
      R_IDLE: if (s_arvalid && s_arready_q) begin
        s_rid_d = s_arid;
        m_araddr_d = ADDR_W'(s_araddr[WINDOW_W-1:0]);
        m_arprot_d = s_arprot;
        if (s_arlen == 4'd0) begin
          r_st_d = R_ISSUE;
          m_arvalid_d = 1'b1;
        end else begin
          r_st_d = R_ERR;
          cnt_d = s_arlen;
          s_rvalid_d = 1'b1;
          s_rdata_d = '0;
          s_rresp_d = RESP_SLVERR;
          s_rlast_d = 1'b0;
        end
      end
      R_ISSUE: begin
        m_arvalid_d = m_arvalid_q && !m_arready;
        if (m_rready_q && m_rvalid) begin
          r_st_d = R_RESP;
          m_rready_d = 1'b0;
          s_rvalid_d = 1'b1;
          s_rdata_d = m_rdata;
          s_rresp_d = m_rresp;
          s_rlast_d = 1'b1;
        end else m_rready_d = !m_arvalid_d;
      end
      R_RESP: if (s_rready) begin
        r_st_d = R_IDLE;
        s_rvalid_d = 1'b0;
        s_rlast_d = 1'b0;
      end
      R_ERR: if (s_rready) begin
        r_st_d = s_rlast_q ? R_IDLE : R_ERR;
        s_rvalid_d = !s_rlast_q;
        cnt_d = s_rlast_q ? cnt_q : cnt_q - 4'd1;
        s_rlast_d = !s_rlast_q && (cnt_d == 4'd0);
      end
    endcase
    s_arready_d = (r_st_d == R_IDLE);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_st_q <= R_IDLE;
      cnt_q <= '0;
      s_rid_q <= '0;
      s_rdata_q <= '0;
      s_rresp_q <= '0;
      s_rlast_q <= 1'b0;
      s_rvalid_q <= 1'b0;
      s_arready_q <= 1'b0;
      m_araddr_q <= '0;
      m_arprot_q <= '0;
      m_arvalid_q <= 1'b0;
      m_rready_q <= 1'b0;
    end else begin
      r_st_q <= r_st_d;
      cnt_q <= cnt_d;
      s_rid_q <= s_rid_d;
      s_rdata_q <= s_rdata_d;
      s_rresp_q <= s_rresp_d;
      s_rlast_q <= s_rlast_d;
      s_rvalid_q <= s_rvalid_d;
      s_arready_q <= s_arready_d;
      m_araddr_q <= m_araddr_d;
      m_arprot_q <= m_arprot_d;
      m_arvalid_q <= m_arvalid_d;
      m_rready_q <= m_rready_d;
    end
  end
  assign s_arready = s_arready_q;
  assign s_rid = s_rid_q;
  assign s_rdata = s_rdata_q;
  assign s_rresp = s_rresp_q;
  assign s_rlast = s_rlast_q;
  assign s_rvalid = s_rvalid_q;
  assign m_araddr = m_araddr_q;
  assign m_arprot = m_arprot_q;
  assign m_arvalid = m_arvalid_q;
  assign m_rready = m_rready_q;
endmodule

// File: rtl/axi_gp_lite_bridge.sv
// axi_gp_lite_bridge: PS7 AXI3 slave to single-beat AXI-lite master, one outstanding write and read.
module axi_gp_lite_bridge import axi_gp_pkg::*; #(
  parameter int ID_W = 12,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WINDOW_W = 12
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ID_W-1:0]     s_awid,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [3:0]          s_awlen,
  input  logic [2:0]          s_awprot,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [ID_W-1:0]     s_wid,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [ID_W-1:0]     s_bid,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ID_W-1:0]     s_arid,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [3:0]          s_arlen,
  input  logic [2:0]          s_arprot,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [ID_W-1:0]     s_rid,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [2:0]          m_awprot,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [2:0]          m_arprot,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready
);
  w_state_e w_st_q, w_st_d;
  logic aw_held_q, aw_held_d, w_held_q, w_held_d, wlast_q, wlast_d;
  logic [ID_W-1:0] awid_q, awid_d, wid_q, wid_d, s_bid_q, s_bid_d;
  logic [3:0] awlen_q, awlen_d;
  logic [ADDR_W-1:0] m_awaddr_q, m_awaddr_d;
  logic [2:0] m_awprot_q, m_awprot_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W/8-1:0] m_wstrb_q, m_wstrb_d;
  logic [1:0] s_bresp_q, s_bresp_d;
  logic m_awvalid_q, m_awvalid_d, m_wvalid_q, m_wvalid_d, m_bready_q, m_bready_d;
  logic s_awready_q, s_awready_d, s_wready_q, s_wready_d, s_bvalid_q, s_bvalid_d;
  logic aw_hs, w_hs;
  assign aw_hs = s_awvalid && s_awready_q;
  assign w_hs = s_wvalid && s_wready_q;
  always_comb begin
    w_st_d = w_st_q;
    aw_held_d = aw_held_q;
    w_held_d = w_held_q;
    wlast_d = wlast_q;
    awid_d = awid_q;
    wid_d = wid_q;
    awlen_d = awlen_q;
    m_awaddr_d = m_awaddr_q;
    m_awprot_d = m_awprot_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
    m_awvalid_d = m_awvalid_q;
    m_wvalid_d = m_wvalid_q;
    m_bready_d = m_bready_q;
    s_bvalid_d = s_bvalid_q;
    s_bresp_d = s_bresp_q;
    s_bid_d = s_bid_q;
    case (w_st_q)
      W_IDLE, W_COLLECT: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awid_d = s_awid;
          awlen_d = s_awlen;
          m_awaddr_d = ADDR_W'(s_awaddr[WINDOW_W-1:0]);
          m_awprot_d = s_awprot;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wid_d = s_wid;
          wlast_d = s_wlast;
          m_wdata_d = s_wdata;
          m_wstrb_d = s_wstrb;
        end
        // Burst length is decided on the cycle AW and the first W beat are both in hand.
        if (aw_held_d && w_held_d) begin
          aw_held_d = 1'b0;
          w_held_d = 1'b0;
          if (awlen_d == 4'd0) begin
            w_st_d = W_ISSUE;
            m_awvalid_d = 1'b1;
            m_wvalid_d = 1'b1;
          end else if (wlast_d) begin
            w_st_d = W_RESP;
            s_bvalid_d = 1'b1;
            s_bresp_d = RESP_SLVERR;
            s_bid_d = awid_d;
          end else w_st_d = W_DRAIN;
        end else if (aw_held_d || w_held_d) w_st_d = W_COLLECT;
      end
      W_ISSUE: begin
        m_awvalid_d = m_awvalid_q && !m_awready;
        m_wvalid_d = m_wvalid_q && !m_wready;
        if (m_bready_q && m_bvalid) begin
          w_st_d = W_RESP;
          m_bready_d = 1'b0;
          s_bvalid_d = 1'b1;
          s_bresp_d = (wid_q != awid_q) ? RESP_SLVERR : m_bresp;
          s_bid_d = awid_q;
        end else m_bready_d = !m_awvalid_d && !m_wvalid_d;
      end
      W_DRAIN: if (w_hs && s_wlast) begin
        w_st_d = W_RESP;
        s_bvalid_d = 1'b1;
        s_bresp_d = RESP_SLVERR;
        s_bid_d = awid_q;
      end
      W_RESP: if (s_bready) begin
        w_st_d = W_IDLE;
        s_bvalid_d = 1'b0;
      end
    endcase
    s_awready_d = (w_st_d == W_IDLE) || (w_st_d == W_COLLECT && !aw_held_d);
    s_wready_d = (w_st_d == W_IDLE) || (w_st_d == W_COLLECT && !w_held_d) || (w_st_d == W_DRAIN);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_st_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q <= 1'b0;
      wlast_q <= 1'b0;
      awid_q <= '0;
      wid_q <= '0;
      awlen_q <= '0;
      m_awaddr_q <= '0;
      m_awprot_q <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
      m_awvalid_q <= 1'b0;
      m_wvalid_q <= 1'b0;
      m_bready_q <= 1'b0;
      s_awready_q <= 1'b0;
      s_wready_q <= 1'b0;
      s_bvalid_q <= 1'b0;
      s_bresp_q <= '0;
      s_bid_q <= '0;
    end else begin
      w_st_q <= w_st_d;
      aw_held_q <= aw_held_d;
      w_held_q <= w_held_d;
      wlast_q <= wlast_d;
      awid_q <= awid_d;
      wid_q <= wid_d;
      awlen_q <= awlen_d;
      m_awaddr_q <= m_awaddr_d;
      m_awprot_q <= m_awprot_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
      m_awvalid_q <= m_awvalid_d;
      m_wvalid_q <= m_wvalid_d;
      m_bready_q <= m_bready_d;
      s_awready_q <= s_awready_d;
      s_wready_q <= s_wready_d;
      s_bvalid_q <= s_bvalid_d;
      s_bresp_q <= s_bresp_d;
      s_bid_q <= s_bid_d;
    end
  end
  assign s_awready = s_awready_q;
  assign s_wready = s_wready_q;
  assign s_bid = s_bid_q;
  assign s_bresp = s_bresp_q;
  assign s_bvalid = s_bvalid_q;
  assign m_awaddr = m_awaddr_q;
  assign m_awprot = m_awprot_q;
  assign m_awvalid = m_awvalid_q;
  assign m_wdata = m_wdata_q;
  assign m_wstrb = m_wstrb_q;
  assign m_wvalid = m_wvalid_q;
  assign m_bready = m_bready_q;
  axi_gp_rd_chan #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WINDOW_W(WINDOW_W)) u_rd (.*);
endmodule
